// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register slice: ALU control codes,
// register-number type, held control payload and the forwarding-hit helper.
package id_ex_stage_pkg;

    typedef logic [4:0] reg_t;

    localparam reg_t REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RAND = 3'b011,
        ALU_ROR  = 3'b100,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    // Control portion of the instruction held in the stage
    typedef struct packed {
        reg_t       rs;
        reg_t       rt;
        reg_t       rdst;
        logic [2:0] alucont;
        logic       alusrc;
        logic       regwrite;
    } idex_ctrl_t;

    // A producer forwards to r only when it writes back r and r is not $zero
    function automatic logic fwd_hit(input logic wr_en, input reg_t wr_dst, input reg_t r);
        return wr_en && (wr_dst == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side handshake/payload bundle of the ID/EX stage.
// slave = the stage itself, master = its environment (decode + execute).
interface id_ex_stage_if #(parameter int N = 32);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_rd1;
    logic [N-1:0] in_rd2;
    logic [4:0]   in_rs;
    logic [4:0]   in_rt;
    logic [4:0]   in_rdst;
    logic [15:0]  in_imm16;
    logic [2:0]   in_alucont;
    logic         in_alusrc;
    logic         in_signext;
    logic         in_regwrite;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_cont;
    logic [4:0]   out_rdst;
    logic         out_regwrite;
    logic [N-1:0] out_store_data;

    modport slave (
        input  in_valid, in_rd1, in_rd2, in_rs, in_rt, in_rdst, in_imm16,
               in_alucont, in_alusrc, in_signext, in_regwrite, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_cont, out_rdst,
               out_regwrite, out_store_data
    );

    modport master (
        output in_valid, in_rd1, in_rd2, in_rs, in_rt, in_rdst, in_imm16,
               in_alucont, in_alusrc, in_signext, in_regwrite, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_cont, out_rdst,
               out_regwrite, out_store_data
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of a register,
// falls back to the captured operand, and pins register 0 to zero.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  reg_t         regnum,
    input  logic         exmem_regwrite,
    input  reg_t         exmem_rdst,
    input  logic [N-1:0] exmem_result,
    input  logic         memwb_regwrite,
    input  reg_t         memwb_rdst,
    input  logic [N-1:0] memwb_result,
    input  logic [N-1:0] captured,
    output logic [N-1:0] fwd
);

    // EX/MEM is younger than MEM/WB, so it is tested first
    always_comb begin
        fwd = captured;
        if (regnum == REG_ZERO) begin
            fwd = '0;
        end else if (fwd_hit(exmem_regwrite, exmem_rdst, regnum)) begin
            fwd = exmem_result;
        end else if (fwd_hit(memwb_regwrite, memwb_rdst, regnum)) begin
            fwd = memwb_result;
        end else begin
            fwd = captured;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: one-entry elastic register between decode and execute.
// Extends the immediate at capture, presents ALU operands combinationally from
// held state. Optional build macro IDEX_FORWARD_EN adds EX/MEM and MEM/WB
// operand forwarding and refreshes held operands while stalled; without it the
// forwarding ports are present but ignored. Valid range: 16 <= N.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          resetn,
    id_ex_stage_if.slave  bus,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [4:0]    exmem_rdst,
    input  logic [N-1:0]  exmem_result,
    input  logic          memwb_regwrite,
    input  logic [4:0]    memwb_rdst,
    input  logic [N-1:0]  memwb_result
);

    logic         valid_r;
    idex_ctrl_t   ctrl_r;
    logic [N-1:0] opa_r;
    logic [N-1:0] opb_r;
    logic [N-1:0] imm_r;

    logic         in_ready_s;
    logic         accept_s;
    logic [N-1:0] imm_ext_s;
    logic [N-1:0] fwd_a_s;
    logic [N-1:0] fwd_b_s;

    // Handshake: accept whenever the slot is empty or is being drained now
    always_comb begin
        in_ready_s = (!valid_r) || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Immediate extension happens before capture so the held value is final
    always_comb begin
        imm_ext_s = {{(N-16){bus.in_signext & bus.in_imm16[15]}}, bus.in_imm16};
    end

`ifdef IDEX_FORWARD_EN
    fwd_mux #(.N(N)) u_fwd_a (
        .regnum         (ctrl_r.rs),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rdst     (exmem_rdst),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rdst     (memwb_rdst),
        .memwb_result   (memwb_result),
        .captured       (opa_r),
        .fwd            (fwd_a_s)
    );

    fwd_mux #(.N(N)) u_fwd_b (
        .regnum         (ctrl_r.rt),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rdst     (exmem_rdst),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rdst     (memwb_rdst),
        .memwb_result   (memwb_result),
        .captured       (opb_r),
        .fwd            (fwd_b_s)
    );
`else
    logic unused_fwd_s;

    // Without forwarding the operands are exactly what was read at decode
    always_comb begin
        fwd_a_s      = opa_r;
        fwd_b_s      = opb_r;
        unused_fwd_s = ^{exmem_regwrite, exmem_rdst, exmem_result,
                         memwb_regwrite, memwb_rdst, memwb_result,
                         ctrl_r.rs, ctrl_r.rt};
    end
`endif

    // Occupancy and payload: reset, flush, capture, drain, or stall refresh
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            opa_r   <= '0;
            opb_r   <= '0;
            imm_r   <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r         <= 1'b1;
            ctrl_r.rs       <= bus.in_rs;
            ctrl_r.rt       <= bus.in_rt;
            ctrl_r.rdst     <= bus.in_rdst;
            ctrl_r.alucont  <= bus.in_alucont;
            ctrl_r.alusrc   <= bus.in_alusrc;
            ctrl_r.regwrite <= bus.in_regwrite;
            opa_r           <= bus.in_rd1;
            opb_r           <= bus.in_rd2;
            imm_r           <= imm_ext_s;
        end else if (valid_r && bus.out_ready) begin
            valid_r <= 1'b0;
        end else if (valid_r) begin
`ifdef IDEX_FORWARD_EN
            // A write-back seen while stalled must survive its single cycle
            opa_r <= fwd_a_s;
            opb_r <= fwd_b_s;
`else
            opa_r <= opa_r;
            opb_r <= opb_r;
`endif
        end else begin
            valid_r <= valid_r;
        end
    end

    // Outputs are taken straight from held state and the forwarding muxes
    always_comb begin
        bus.in_ready       = in_ready_s;
        bus.out_valid      = valid_r;
        bus.alu_a          = fwd_a_s;
        bus.alu_b          = ctrl_r.alusrc ? imm_r : fwd_b_s;
        bus.alu_cont       = ctrl_r.alucont;
        bus.out_rdst       = ctrl_r.rdst;
        bus.out_regwrite   = ctrl_r.regwrite;
        bus.out_store_data = fwd_b_s;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven back-to-back flow with a
// scoreboard queue, plus directed sequences for forwarding, stall refresh,
// flush and reset. Expectations follow the IDEX_FORWARD_EN setting.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         exmem_regwrite;
    logic [4:0]   exmem_rdst;
    logic [N-1:0] exmem_result;
    logic         memwb_regwrite;
    logic [4:0]   memwb_rdst;
    logic [N-1:0] memwb_result;

    id_ex_stage_if #(.N(N)) bus ();

    id_ex_stage #(.N(N)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .flush          (flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rdst     (exmem_rdst),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rdst     (memwb_rdst),
        .memwb_result   (memwb_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rdst;
        logic [15:0]  imm;
        logic [2:0]   cont;
        logic         alusrc;
        logic         signext;
        logic         rw;
        logic [N-1:0] exp_a;
        logic [N-1:0] exp_b;
    } vec_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] st;
        logic [2:0]   cont;
        logic [4:0]   rdst;
        logic         rw;
    } exp_t;

    vec_t tbl[6];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mkv(input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rdst, input logic [15:0] imm,
                                 input logic [2:0] cont, input logic alusrc,
                                 input logic signext, input logic rw,
                                 input logic [N-1:0] exp_a, input logic [N-1:0] exp_b);
        vec_t v;
        v.rd1 = rd1; v.rd2 = rd2; v.rs = rs; v.rt = rt; v.rdst = rdst;
        v.imm = imm; v.cont = cont; v.alusrc = alusrc; v.signext = signext;
        v.rw = rw; v.exp_a = exp_a; v.exp_b = exp_b;
        return v;
    endfunction

    // Reference forwarding rule, evaluated on the bench's own stimulus
    function automatic logic [N-1:0] model_fwd(input logic [4:0] r, input logic [N-1:0] cap);
`ifdef IDEX_FORWARD_EN
        if (r == 5'd0) return '0;
        if (exmem_regwrite && exmem_rdst == r) return exmem_result;
        if (memwb_regwrite && memwb_rdst == r) return memwb_result;
        return cap;
`else
        return cap;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_rd1      = v.rd1;
        bus.in_rd2      = v.rd2;
        bus.in_rs       = v.rs;
        bus.in_rt       = v.rt;
        bus.in_rdst     = v.rdst;
        bus.in_imm16    = v.imm;
        bus.in_alucont  = v.cont;
        bus.in_alusrc   = v.alusrc;
        bus.in_signext  = v.signext;
        bus.in_regwrite = v.rw;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_alu_a"},    {32'd0, bus.alu_a},          {32'd0, e.a});
            chk({tag, "_alu_b"},    {32'd0, bus.alu_b},          {32'd0, e.b});
            chk({tag, "_store"},    {32'd0, bus.out_store_data}, {32'd0, e.st});
            chk({tag, "_alu_cont"}, {61'd0, bus.alu_cont},       {61'd0, e.cont});
            chk({tag, "_rdst"},     {59'd0, bus.out_rdst},       {59'd0, e.rdst});
            chk({tag, "_regwrite"}, {63'd0, bus.out_regwrite},   {63'd0, e.rw});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [N-1:0] exp_st;

        tbl[0] = mkv(32'd5,          32'd7,    5'd1,  5'd2,  5'd3,  16'h0000, ALU_ADD, 1'b0, 1'b0, 1'b1, 32'd5,          32'd7);
        tbl[1] = mkv(32'h10,         32'h20,   5'd4,  5'd5,  5'd6,  16'h1234, ALU_ADD, 1'b0, 1'b1, 1'b1, 32'h10,         32'h20);
        tbl[2] = mkv(32'd1,          32'd9,    5'd1,  5'd2,  5'd8,  16'hFFFF, ALU_OR,  1'b1, 1'b1, 1'b1, 32'd1,          32'hFFFF_FFFF);
        tbl[3] = mkv(32'd2,          32'd9,    5'd1,  5'd2,  5'd8,  16'hFFFF, ALU_AND, 1'b1, 1'b0, 1'b1, 32'd2,          32'h0000_FFFF);
        tbl[4] = mkv(32'hDEAD_BEEF,  32'd3,    5'd9,  5'd10, 5'd12, 16'h8000, ALU_SUB, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF,  32'hFFFF_8000);
        tbl[5] = mkv(32'h42,         32'h77,   5'd30, 5'd31, 5'd31, 16'h7FFF, ALU_SLT, 1'b1, 1'b1, 1'b0, 32'h42,         32'h0000_7FFF);

        // Reset held for two edges with a valid request pending
        resetn         = 1'b0;
        flush          = 1'b0;
        exmem_regwrite = 1'b0; exmem_rdst = 5'd0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rdst = 5'd0; memwb_result = '0;
        bus.out_ready  = 1'b1;
        drive(tbl[0]);
        bus.in_valid   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {63'd0, bus.out_valid},    64'd0);
        chk("reset_in_ready",  {63'd0, bus.in_ready},     64'd1);
        chk("reset_alu_cont",  {61'd0, bus.alu_cont},     64'd0);
        chk("reset_rdst",      {59'd0, bus.out_rdst},     64'd0);
        chk("reset_regwrite",  {63'd0, bus.out_regwrite}, 64'd0);
        chk("reset_alu_a",     {32'd0, bus.alu_a},        64'd0);
        chk("reset_store",     {32'd0, bus.out_store_data}, 64'd0);

        // Back-to-back stream, one instruction per cycle
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) compare_out($sformatf("vec%0d", i - 1));
            chk($sformatf("vec%0d_in_ready", i), {63'd0, bus.in_ready}, 64'd1);
            @(posedge clk);
            e.a = tbl[i].exp_a; e.b = tbl[i].exp_b; e.st = tbl[i].rd2;
            e.cont = tbl[i].cont; e.rdst = tbl[i].rdst; e.rw = tbl[i].rw;
            sb_q.push_back(e);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        compare_out("vec5");
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Forwarding priority on rs=3 while stalled
        @(posedge clk); #1;
        drive(mkv(32'hAA, 32'hBB, 5'd3, 5'd5, 5'd7, 16'h0000, ALU_ADD, 1'b0, 1'b0, 1'b1, '0, '0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exmem_regwrite = 1'b1; exmem_rdst = 5'd3; exmem_result = 32'h11;
        memwb_regwrite = 1'b1; memwb_rdst = 5'd3; memwb_result = 32'h22;
        #1;
        chk("fwd_both_alu_a", {32'd0, bus.alu_a}, {32'd0, model_fwd(5'd3, 32'hAA)});
        chk("fwd_stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        exmem_regwrite = 1'b0;
        #1;
        chk("fwd_memwb_alu_a", {32'd0, bus.alu_a}, {32'd0, model_fwd(5'd3, 32'hAA)});
        memwb_regwrite = 1'b0;
        #1;
        chk("fwd_none_alu_a", {32'd0, bus.alu_a}, 64'hAA);
        chk("fwd_none_store", {32'd0, bus.out_store_data}, 64'hBB);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Register 0 never forwards
        drive(mkv(32'h5A, 32'h66, 5'd0, 5'd6, 5'd7, 16'h0000, ALU_ADD, 1'b0, 1'b0, 1'b1, '0, '0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exmem_regwrite = 1'b1; exmem_rdst = 5'd0; exmem_result = 32'h11;
        memwb_regwrite = 1'b1; memwb_rdst = 5'd0; memwb_result = 32'h22;
        #1;
        chk("r0_alu_a", {32'd0, bus.alu_a}, {32'd0, model_fwd(5'd0, 32'h5A)});
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b0;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;

        // Stall refresh: a one-cycle MEM/WB write of rt must stick
        drive(mkv(32'h1, 32'h44, 5'd7, 5'd4, 5'd9, 16'h0000, ALU_ADD, 1'b0, 1'b0, 1'b1, '0, '0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        memwb_regwrite = 1'b1; memwb_rdst = 5'd4; memwb_result = 32'h99;
        @(posedge clk); #1;
        memwb_regwrite = 1'b0;
`ifdef IDEX_FORWARD_EN
        exp_st = 32'h99;
`else
        exp_st = 32'h44;
`endif
        @(negedge clk);
        chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_in_ready",  {63'd0, bus.in_ready},  64'd0);
        chk("stall_store",     {32'd0, bus.out_store_data}, {32'd0, exp_st});
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_store", {32'd0, bus.out_store_data}, {32'd0, exp_st});
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Flush while full with a same-cycle accept
        @(posedge clk); #1;
        drive(mkv(32'h3, 32'h4, 5'd1, 5'd2, 5'd3, 16'h0000, ALU_ADD, 1'b0, 1'b0, 1'b1, '0, '0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(mkv(32'h5, 32'h6, 5'd1, 5'd2, 5'd4, 16'h0000, ALU_SUB, 1'b0, 1'b0, 1'b1, '0, '0));
        flush = 1'b1;
        @(negedge clk);
        chk("flush_full_before", {63'd0, bus.out_valid}, 64'd1);
        chk("flush_in_ready",    {63'd0, bus.in_ready},  64'd1);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_stays_empty", {63'd0, bus.out_valid}, 64'd0);

        // Reset in the middle of a stalled transfer
        @(posedge clk); #1;
        drive(mkv(32'h7, 32'h8, 5'd2, 5'd3, 5'd5, 16'h0000, ALU_OR, 1'b0, 1'b0, 1'b1, '0, '0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        resetn        = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("midrst_alu_cont",  {61'd0, bus.alu_cont},  64'd0);
        chk("midrst_rdst",      {59'd0, bus.out_rdst},  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter N, default 32, datapath width of operands and results.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  decode-side handshake; transfer when both high.
REQ-005 in_rd1, in_rd2  input  N  register-file read values for rs, rt.
REQ-006 in_rs, in_rt, in_rdst  input  5 each  source and destination register numbers.
REQ-007 in_imm16  input  16  instruction immediate.
REQ-008 in_alucont  input  3  ALU control code (ADD/AND/OR/RAND/ROR/SLT/SUB encodings).
REQ-009 in_alusrc, in_signext, in_regwrite  input  1 each  B-source select (1 = immediate), immediate extension mode (1 = sign), write-back enable.
REQ-010 flush  input  1  kill the held instruction and any instruction accepted this cycle.
REQ-011 exmem_regwrite, exmem_rdst, exmem_result  input  1/5/N  forwarding source, older stage.
REQ-012 memwb_regwrite, memwb_rdst, memwb_result  input  1/5/N  forwarding source, oldest stage.
REQ-013 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-014 alu_a, alu_b, alu_cont  output  N/N/3  operands and control driven straight into the ALU.
REQ-015 out_rdst, out_regwrite, out_store_data  output  5/1/N  destination, write enable, forwarded rt value.

Function
REQ-016 Stage SHALL hold one instruction; state EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational, no bubble on continuous flow).
REQ-018 EMPTY->FULL on in_valid&&in_ready; FULL->FULL on transfer with new accept; FULL->EMPTY on out_ready&&!accept.
REQ-019 Latency SHALL be one cycle from accept to out_valid.
REQ-020 flush SHALL force out_valid=0 next cycle, overriding any same-cycle accept; flush while EMPTY is a no-op.
REQ-021 Immediate SHALL be extended to N bits: sign-extend when in_signext=1, else zero-extend; extension performed at capture.
REQ-022 Forwarded rs value: exmem_result if exmem_regwrite && exmem_rdst==rs && rs!=0; else memwb_result under same rule; else captured operand.
REQ-023 EX/MEM match SHALL win over MEM/WB on simultaneous match; register 0 SHALL never forward and SHALL read 0.
REQ-024 Same rule SHALL apply to rt, producing out_store_data.
REQ-025 alu_a = forwarded rs; alu_b = extended immediate if alusrc else forwarded rt; alu_cont = held code.
REQ-026 While FULL and !out_ready, operand registers SHALL reload with forwarded rs/rt values each cycle so a write-back seen during a stall is not lost.
REQ-027 Forwarding mux is combinational on held state; no added latency.
REQ-028 Outputs other than out_valid SHALL be don't-care when out_valid=0 but SHALL not change without a clock edge unless forwarding inputs change.

Reset
REQ-029 resetn=0 at a rising edge SHALL clear out_valid, out_regwrite, out_rdst, alu_cont and operand registers to 0.
REQ-030 Reset mid-operation SHALL drop the held instruction without completing the handshake; in_ready SHALL be 1 the cycle after reset release.

Configuration
REQ-031 Macro IDEX_FORWARD_EN compiled in: REQ-022..REQ-024 and REQ-026 active.
REQ-032 Without IDEX_FORWARD_EN: forwarding inputs ignored, alu_a/out_store_data are captured rd1/rd2, no stall refresh; port list unchanged.

Structure
REQ-033 Shared package SHALL hold the 3-bit ALU control encodings, the 5-bit register-number type and the stage payload struct.
REQ-034 One sub-module fwd_mux (register number + two sources + captured value -> forwarded value), instantiated twice.

Verification
REQ-035 Reset: resetn=0 two cycles with in_valid=1 -> out_valid=0, in_ready=1 after release.
REQ-036 Back-to-back ADD, out_ready=1: rd1=5, rd2=7, alusrc=0 -> next cycle alu_a=5, alu_b=7, alu_cont=ADD, one instruction per cycle.
REQ-037 Immediate: imm16=0xFFFF, signext=1 -> alu_b=0xFFFFFFFF; signext=0 -> alu_b=0x0000FFFF.
REQ-038 Forwarding priority: rs=3, exmem(rdst=3,result=0x11), memwb(rdst=3,result=0x22) -> alu_a=0x11; rs=0 with both matching rdst=0 -> alu_a=0.
REQ-039 Stall refresh: FULL, out_ready=0, memwb writes rt=4 value 0x99 for one cycle, then out_ready=1 -> out_store_data=0x99.
REQ-040 Flush: FULL with in_valid=1 and flush=1 same cycle -> out_valid=0 next cycle, accepted instruction discarded.
